// File: rtl/delay_tap_capture.sv
// Launches an edge into an external delay chain, samples its taps through a
// two-stage capture/synchroniser path and decodes the thermometer code.
module delay_tap_capture #(
  parameter int N_TAPS = 16,
  parameter int CNT_W  = $clog2(N_TAPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              launch,
  input  logic [N_TAPS-1:0] taps,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_bubble,
  output logic              res_sat,
  output logic [CNT_W-1:0]  stat_min,
  output logic [CNT_W-1:0]  stat_max,
  input  logic              clr_stats
);

  typedef enum logic [2:0] {IDLE, CAP, SYNC, DEC, HOLD} state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_TAPS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t              state_q;
  logic                launch_q;
  logic [N_TAPS-1:0]   cap_q;
  logic [N_TAPS-1:0]   sync_q;
  logic                valid_q;
  logic [CNT_W-1:0]    count_q;
  logic                bubble_q;
  logic                sat_q;
  logic [CNT_W-1:0]    min_q;
  logic [CNT_W-1:0]    max_q;

  logic [N_TAPS-1:0]   arrived;
  logic [CNT_W-1:0]    count_d;
  logic                bubble_d;
  logic                sat_d;
  logic                run;

  // A tap has "arrived" when it already shows the polarity just launched.
  generate
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_arrived
      assign arrived[gi] = sync_q[gi] ~^ launch_q;
    end
  endgenerate

  always_comb begin
    count_d  = '0;
    bubble_d = 1'b0;
    run      = 1'b1;
    for (int i = 0; i < N_TAPS; i++) begin
      if (run && arrived[i]) begin
        count_d = count_d + ONE;
      end else if (arrived[i]) begin
        bubble_d = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    sat_d = (count_d == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      launch_q <= 1'b0;
      cap_q    <= '0;
      sync_q   <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      bubble_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            launch_q <= ~launch_q;
            state_q  <= CAP;
          end
        end
        CAP: begin
          cap_q   <= taps;
          state_q <= SYNC;
        end
        SYNC: begin
          sync_q  <= cap_q;
          state_q <= DEC;
        end
        DEC: begin
          count_q  <= count_d;
          bubble_q <= bubble_d;
          sat_q    <= sat_d;
          valid_q  <= 1'b1;
          state_q  <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A clear landing on the decode cycle seeds both bounds with the new count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= FULL;
      max_q <= '0;
    end else if (state_q == DEC) begin
      if (clr_stats) begin
        min_q <= count_d;
        max_q <= count_d;
      end else begin
        if (count_d < min_q) min_q <= count_d;
        if (count_d > max_q) max_q <= count_d;
      end
    end else if (clr_stats) begin
      min_q <= FULL;
      max_q <= '0;
    end
  end

  assign launch     = launch_q;
  assign busy       = (state_q != IDLE);
  assign res_valid  = valid_q;
  assign res_count  = count_q;
  assign res_bubble = bubble_q;
  assign res_sat    = sat_q;
  assign stat_min   = min_q;
  assign stat_max   = max_q;

endmodule

// File: tb/tb_delay_tap_capture.sv
// Directed bench for delay_tap_capture: hand-computed thermometer decodes,
// handshake holding, statistics clearing and reset abort.
module tb_delay_tap_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        launch;
  logic [15:0] taps = 16'h0000;
  logic        busy;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [4:0]  res_count;
  logic        res_bubble;
  logic        res_sat;
  logic [4:0]  stat_min;
  logic [4:0]  stat_max;
  logic        clr_stats = 1'b0;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  delay_tap_capture #(.N_TAPS(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .launch     (launch),
    .taps       (taps),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .res_bubble (res_bubble),
    .res_sat    (res_sat),
    .stat_min   (stat_min),
    .stat_max   (stat_max),
    .clr_stats  (clr_stats)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic measure(input logic [15:0] t, input logic e_launch, input int e_cnt,
                         input logic e_bub, input logic e_sat, input int e_min,
                         input int e_max, input logic do_clr, input logic do_ack);
    int lat;
    @(negedge clk);
    start = 1'b1;
    taps  = t;
    @(negedge clk);
    start = 1'b0;
    check_val("launch", 32'(launch), 32'(e_launch));
    check_val("busy_run", 32'(busy), 32'd1);
    lat = 0;
    while (!res_valid && lat < 10) begin
      clr_stats = do_clr && (lat == 2);
      @(negedge clk);
      lat++;
    end
    clr_stats = 1'b0;
    check_val("latency", 32'(lat), 32'd3);
    check_val("count", 32'(res_count), 32'(e_cnt));
    check_val("bubble", 32'(res_bubble), 32'(e_bub));
    check_val("sat", 32'(res_sat), 32'(e_sat));
    check_val("stat_min", 32'(stat_min), 32'(e_min));
    check_val("stat_max", 32'(stat_max), 32'(e_max));
    $display("meas taps=%04h launch=%0d count=%0d bubble=%0d sat=%0d min=%0d max=%0d lat=%0d",
             t, launch, res_count, res_bubble, res_sat, stat_min, stat_max, lat);
    if (do_ack) begin
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check_val("valid_drop", 32'(res_valid), 32'd0);
      check_val("busy_idle", 32'(busy), 32'd0);
      check_val("count_keep", 32'(res_count), 32'(e_cnt));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_launch", 32'(launch), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_valid", 32'(res_valid), 32'd0);
    check_val("rst_count", 32'(res_count), 32'd0);
    check_val("rst_bubble", 32'(res_bubble), 32'd0);
    check_val("rst_sat", 32'(res_sat), 32'd0);
    check_val("rst_min", 32'(stat_min), 32'd16);
    check_val("rst_max", 32'(stat_max), 32'd0);
    rst = 1'b0;

    //       taps      lnch cnt bub sat min max clr ack
    measure(16'h001F, 1'b1, 5,  0,  0,  5,  5,  0,  1);
    measure(16'hFF00, 1'b0, 8,  0,  0,  5,  8,  0,  1);
    measure(16'h00F7, 1'b1, 3,  1,  0,  3,  8,  0,  1);
    measure(16'h0F0F, 1'b0, 0,  1,  0,  0,  8,  0,  1);
    measure(16'hFFFF, 1'b1, 16, 0,  1,  0,  16, 0,  1);
    measure(16'hFFFE, 1'b0, 1,  0,  0,  0,  16, 0,  0);

    // Consumer stalls while start pulses; nothing may move.
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      taps  = 16'(i * 16'h1111);
      @(negedge clk);
      check_val("hold_valid", 32'(res_valid), 32'd1);
      check_val("hold_busy", 32'(busy), 32'd1);
      check_val("hold_count", 32'(res_count), 32'd1);
      check_val("hold_launch", 32'(launch), 32'd0);
    end
    start     = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    res_ready = 1'b0;
    check_val("ack_valid", 32'(res_valid), 32'd0);
    check_val("ack_busy", 32'(busy), 32'd0);
    check_val("ack_launch", 32'(launch), 32'd0);
    @(negedge clk);
    check_val("no_queue_busy", 32'(busy), 32'd0);
    check_val("retain_count", 32'(res_count), 32'd1);

    measure(16'h0003, 1'b1, 2,  0,  0,  2,  2,  1,  1);
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    check_val("clr_min", 32'(stat_min), 32'd16);
    check_val("clr_max", 32'(stat_max), 32'd0);

    measure(16'hFFF0, 1'b0, 4,  0,  0,  4,  4,  0,  1);

    // Abort a measurement while it sits in SYNC.
    @(negedge clk);
    start = 1'b1;
    taps  = 16'h00FF;
    @(negedge clk);
    start = 1'b0;
    check_val("abort_launch_hi", 32'(launch), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort_launch", 32'(launch), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_min", 32'(stat_min), 32'd16);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("abort_no_valid", 32'(res_valid), 32'd0);
    end
    measure(16'h007F, 1'b1, 7,  0,  0,  7,  7,  0,  1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/delay_tap_capture.md
DELAY_TAP_CAPTURE -- requirements
Module: delay_tap_capture

Interface
REQ-001 SHALL have parameter N_TAPS, default 16, number of delay-chain tap outputs sampled (range 2..64).
REQ-002 SHALL have parameter CNT_W, default 5, width of count results; SHALL equal clog2(N_TAPS+1).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port start  input  1  request one measurement; sampled in IDLE only.
REQ-007 SHALL have port launch  output  1  registered edge driven into the delay-chain input.
REQ-008 SHALL have port taps  input  N_TAPS  chain tap outputs, tap 0 nearest launch.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port res_valid  output  1  result available.
REQ-011 SHALL have port res_ready  input  1  consumer accepts result.
REQ-012 SHALL have port res_count  output  CNT_W  taps reached by the launched edge.
REQ-013 SHALL have port res_bubble  output  1  thermometer code non-monotonic.
REQ-014 SHALL have port res_sat  output  1  edge reached every tap.
REQ-015 SHALL have port stat_min  output  CNT_W  minimum res_count since last clear.
REQ-016 SHALL have port stat_max  output  CNT_W  maximum res_count since last clear.
REQ-017 SHALL have port clr_stats  input  1  synchronous clear of stat_min/stat_max.

Function
REQ-018 SHALL implement the FSM states IDLE, CAP, SYNC, DEC, HOLD.
REQ-019 IDLE with start=1 SHALL, at that edge, invert launch and go to CAP; start=0 SHALL leave IDLE unchanged.
REQ-020 CAP SHALL register taps into cap_reg and go to SYNC.
REQ-021 SYNC SHALL copy cap_reg into sync_reg, a metastability stage, and go to DEC.
REQ-022 DEC SHALL register the results, set res_valid=1 and go to HOLD; res_valid SHALL rise exactly 3 cycles after the start edge.
REQ-023 Decode: bit i "arrived" SHALL mean sync_reg[i] equals the current launch level.
REQ-024 res_count SHALL equal the number of consecutive arrived bits starting at tap 0, giving 0..N_TAPS.
REQ-025 res_bubble SHALL be 1 iff any arrived bit exists above the first non-arrived bit.
REQ-026 res_sat SHALL be 1 iff res_count equals N_TAPS; res_bubble SHALL then be 0.
REQ-027 HOLD SHALL hold all res_* outputs stable until res_valid and res_ready are both 1, then go to IDLE; res_valid SHALL be 0 the following cycle.
REQ-028 start SHALL be ignored in every state except IDLE, including the HOLD handshake cycle; no request is queued.
REQ-029 res_count, res_bubble and res_sat SHALL retain their last values after the handshake until the next DEC.
REQ-030 In DEC, stat_min SHALL become min(stat_min, count) and stat_max SHALL become max(stat_max, count).
REQ-031 clr_stats SHALL set stat_min=N_TAPS and stat_max=0.
REQ-032 If clr_stats and DEC occur in the same cycle, stat_min and stat_max SHALL both equal the new count.
REQ-033 launch SHALL alternate polarity each measurement, so consecutive measurements test rising and falling edges alternately.

Reset
REQ-034 rst=1 SHALL immediately force: state=IDLE, launch=0, busy=0, res_valid=0, res_count=0, res_bubble=0, res_sat=0, stat_min=N_TAPS, stat_max=0, cap_reg=0, sync_reg=0.
REQ-035 rst asserted mid-measurement SHALL abort it with no result produced, and the first start after release SHALL drive launch to 1.

Verification
REQ-036 Reset, then start pulse with taps=16'h001F -> launch=1; res_valid rises 3 cycles later with res_count=5, res_bubble=0, res_sat=0, stat_min=5, stat_max=5.
REQ-037 Second measurement with launch now 0 and taps=16'hFF00 -> res_count=8, res_bubble=0, stat_min=5, stat_max=8.
REQ-038 Measurement with taps=16'h00F7 at launch=1 -> res_count=3 and res_bubble=1; with taps=16'hFFFF -> res_count=16, res_sat=1, res_bubble=0.
REQ-039 res_ready held 0 for 10 cycles while start pulses -> outputs stable and busy=1; res_ready=1 with start=1 in the same cycle -> return to IDLE with no new launch.
REQ-040 clr_stats coinciding with DEC where count=2 -> stat_min=2, stat_max=2; clr_stats alone -> stat_min=16, stat_max=0.
REQ-041 rst pulse while in SYNC -> res_valid never asserts and launch=0; next start -> launch=1 with a normal result.
